dmem_responder: RTL

//  Memory-side responder for the core's data-memory port: accepts load/store requests over a

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte enables, response 1+WAIT_STATES cycles after accept, held until rsp_ready.
// Define DMEM_MMIO_EN to map a read-only free-running cycle counter at BASE_ADDR+4*DEPTH.
module dmem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic [31:0] mem [DEPTH];

  logic             accept;
  logic             enter_resp;
  logic             t_we;
  logic [31:0]      t_addr;
  logic [31:0]      t_wdata;
  logic [3:0]       t_be;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             misaligned;
  logic             in_ram;
  logic             access_err;
  logic             do_store;
  logic [31:0]      rd_word;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = (state == ST_IDLE) && req_valid;

  // With zero wait states RESP is entered on the accept edge, so decode straight from the request.
  assign t_we    = (state == ST_IDLE) ? req_we    : lat_we;
  assign t_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
  assign t_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
  assign t_be    = (state == ST_IDLE) ? req_be    : lat_be;

  assign offset     = t_addr - BASE_ADDR;
  assign idx        = offset[IDX_W+1:2];
  assign misaligned = (t_addr[1:0] != 2'b00);
  assign in_ram     = (offset < SPAN);

`ifdef DMEM_MMIO_EN
  logic [31:0] cyc_cnt;
  logic        mmio_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  assign mmio_hit   = (offset == SPAN) && !misaligned;
  assign access_err = misaligned || (!in_ram && !mmio_hit) || (mmio_hit && t_we);
  assign rd_word    = mmio_hit ? cyc_cnt : mem[idx];
`else
  assign access_err = misaligned || !in_ram;
  assign rd_word    = mem[idx];
`endif

  always_comb begin
    enter_resp = 1'b0;
    if (state == ST_IDLE) begin
      enter_resp = accept && (WS == 4'd0);
    end else if (state == ST_WAIT) begin
      enter_resp = (wait_cnt == 4'd1);
    end
  end

  // Reset on the commit edge must still drop the pending store.
  assign do_store = enter_resp && !reset && t_we && !access_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= (WS == 4'd0) ? ST_RESP : ST_WAIT;
            wait_cnt <= WS;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (enter_resp) begin
        rsp_err   <= access_err;
        rsp_rdata <= (t_we || access_err) ? 32'd0 : rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (t_be[i]) begin
          mem[idx][8*i +: 8] <= t_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
